// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit, 8-register multicycle CPU control path.
// Covers FSM states, opcodes, mux select encodings and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_LW   = 4'h5,
    OP_SW   = 4'h6,
    OP_BEQ  = 4'h7,
    OP_J    = 4'h8,
    OP_HALT = 4'hF
  } opcode_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_MSB = 11;
  localparam int unsigned RD_LSB = 9;
  localparam int unsigned RS_MSB = 8;
  localparam int unsigned RS_LSB = 6;
  localparam int unsigned RT_MSB = 5;
  localparam int unsigned RT_LSB = 3;

  typedef struct packed {
    logic       reg_we;
    logic       mem_to_reg;
    logic       iord;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic       pc_we_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctl;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for the multicycle CPU.
// Control outputs depend only on the registered state (plus IR fields); ZERO is gated in the datapath.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int OPW = 4,
  parameter int RAW = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [15:0]    INSTR,
  input  logic           ZERO,
  output logic [RAW-1:0] RA1,
  output logic [RAW-1:0] RA2,
  output logic [RAW-1:0] WA3,
  output logic           REG_WE,
  output logic           MEM_TO_REG,
  output logic           IOR_D,
  output logic           MEM_WE,
  output logic           IR_WE,
  output logic           PC_WE,
  output logic           PC_WE_COND,
  output logic [1:0]     PC_SRC,
  output logic           ALU_SRC_A,
  output logic [1:0]     ALU_SRC_B,
  output logic [1:0]     ALU_CTL,
  output logic           HALTED
);

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_bits;
  opcode_t          op;
  ctrl_t            ctl;

  assign op_bits = INSTR[OP_MSB:OP_LSB];
  assign op      = opcode_t'(op_bits);

  // ZERO is consumed by the datapath's PC gating; INSTR[2:0] is imm/unused here.
  logic unused_ok;
  assign unused_ok = ^{ZERO, INSTR[2:0]};

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = S_RESET;
    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_R;
          OP_ADDI:                       state_d = S_EXEC_I;
          OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
          OP_BEQ:                        state_d = S_BRANCH;
          OP_J:                          state_d = S_JUMP;
          OP_HALT:                       state_d = S_HALT;
          default:                       state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_RESET;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.ir_we     = 1'b1;
        ctl.pc_we     = 1'b1;
        ctl.alu_src_b = SRCB_ONE;
        ctl.alu_ctl   = ALU_ADD;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_ctl   = ALU_ADD;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_ctl   = INSTR[OP_LSB+1:OP_LSB];
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_ctl   = ALU_ADD;
      end
      S_ALU_WB: ctl.reg_we = 1'b1;
      S_MEM_RD: ctl.iord   = 1'b1;
      S_MEM_WB: begin
        ctl.reg_we     = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctl.iord   = 1'b1;
        ctl.mem_we = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = SRCB_REG;
        ctl.alu_ctl    = ALU_SUB;
        ctl.pc_we_cond = 1'b1;
        ctl.pc_src     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctl.pc_we  = 1'b1;
        ctl.pc_src = PC_SRC_JUMP;
      end
      S_HALT:  ctl.halted = 1'b1;
      default: ctl = '0;
    endcase
  end

  // Store and branch compare the register named in [11:9], so it goes out on port 2.
  assign RA1 = INSTR[RS_MSB:RS_LSB];
  assign RA2 = (op == OP_SW || op == OP_BEQ) ? INSTR[RD_MSB:RD_LSB] : INSTR[RT_MSB:RT_LSB];
  assign WA3 = INSTR[RD_MSB:RD_LSB];

  assign REG_WE     = ctl.reg_we;
  assign MEM_TO_REG = ctl.mem_to_reg;
  assign IOR_D      = ctl.iord;
  assign MEM_WE     = ctl.mem_we;
  assign IR_WE      = ctl.ir_we;
  assign PC_WE      = ctl.pc_we;
  assign PC_WE_COND = ctl.pc_we_cond;
  assign PC_SRC     = ctl.pc_src;
  assign ALU_SRC_A  = ctl.alu_src_a;
  assign ALU_SRC_B  = ctl.alu_src_b;
  assign ALU_CTL    = ctl.alu_ctl;
  assign HALTED     = ctl.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected control sequences
// built from the opcode, checked cycle by cycle along with address decode and invariants.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] INSTR;
  logic        ZERO;
  logic [2:0]  RA1, RA2, WA3;
  logic        REG_WE, MEM_TO_REG, IOR_D, MEM_WE, IR_WE, PC_WE, PC_WE_COND;
  logic [1:0]  PC_SRC, ALU_SRC_B, ALU_CTL;
  logic        ALU_SRC_A, HALTED;

  always #5 clk = ~clk;

  multicycle_control dut (
    .CLK(clk), .RST(RST), .INSTR(INSTR), .ZERO(ZERO),
    .RA1(RA1), .RA2(RA2), .WA3(WA3),
    .REG_WE(REG_WE), .MEM_TO_REG(MEM_TO_REG), .IOR_D(IOR_D), .MEM_WE(MEM_WE),
    .IR_WE(IR_WE), .PC_WE(PC_WE), .PC_WE_COND(PC_WE_COND), .PC_SRC(PC_SRC),
    .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_CTL(ALU_CTL), .HALTED(HALTED)
  );

  typedef logic [14:0] cw_t;

  int  n_assert = 0;
  int  n_fail   = 0;
  cw_t exp_q[$];
  cw_t obs;

  assign obs = {REG_WE, MEM_TO_REG, IOR_D, MEM_WE, IR_WE, PC_WE, PC_WE_COND,
                PC_SRC, ALU_SRC_A, ALU_SRC_B, ALU_CTL, HALTED};

  function automatic cw_t cw(input logic reg_we, input logic mem_to_reg, input logic iord,
                             input logic mem_we, input logic ir_we, input logic pc_we,
                             input logic pc_we_cond, input logic [1:0] pc_src,
                             input logic src_a, input logic [1:0] src_b,
                             input logic [1:0] alu, input logic halted);
    return {reg_we, mem_to_reg, iord, mem_we, ir_we, pc_we, pc_we_cond,
            pc_src, src_a, src_b, alu, halted};
  endfunction

  // Expected control words, one per cycle, from FETCH up to the instruction's last state.
  task automatic build(input logic [15:0] instr);
    logic [3:0] op;
    cw_t        wb_alu, mem_addr;
    op       = instr[15:12];
    wb_alu   = cw(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    mem_addr = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0);
    exp_q.delete();
    exp_q.push_back(cw(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b01, 2'b00, 0));
    exp_q.push_back(cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0));
    if (op <= 4'd3) begin
      exp_q.push_back(cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, op[1:0], 0));
      exp_q.push_back(wb_alu);
    end else if (op == 4'd4) begin
      exp_q.push_back(mem_addr);
      exp_q.push_back(wb_alu);
    end else if (op == 4'd5) begin
      exp_q.push_back(mem_addr);
      exp_q.push_back(cw(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
      exp_q.push_back(cw(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
    end else if (op == 4'd6) begin
      exp_q.push_back(mem_addr);
      exp_q.push_back(cw(0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
    end else if (op == 4'd7) begin
      exp_q.push_back(cw(0, 0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0));
    end else if (op == 4'd8) begin
      exp_q.push_back(cw(0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 2'b00, 0));
    end else if (op == 4'hF) begin
      repeat (12) exp_q.push_back(cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
    end
  endtask

  task automatic check_cw(input string tag, input cw_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: control word observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_addr(input string tag, input logic [15:0] instr);
    logic [3:0] op;
    logic [8:0] exp;
    op  = instr[15:12];
    exp = {3'((instr >> 6) & 16'd7),
           (op == 4'd6 || op == 4'd7) ? 3'((instr >> 9) & 16'd7) : 3'((instr >> 3) & 16'd7),
           3'((instr >> 9) & 16'd7)};
    n_assert++;
    assert ({RA1, RA2, WA3} === exp) else begin
      n_fail++;
      $error("FAIL %s addr: {RA1,RA2,WA3} observed %h expected %h", tag, {RA1, RA2, WA3}, exp);
    end
  endtask

  task automatic check_inv(input string tag);
    n_assert++;
    assert (!(REG_WE && MEM_WE) && !(PC_WE && PC_WE_COND)) else begin
      n_fail++;
      $error("FAIL %s invariant: REG_WE/MEM_WE/PC_WE/PC_WE_COND observed %b%b%b%b expected exclusive pairs",
             tag, REG_WE, MEM_WE, PC_WE, PC_WE_COND);
    end
  endtask

  // Called at a negedge; holds RST for n edges, checking the all-zero RESET word each cycle.
  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) begin
      @(negedge clk);
      #1;
      check_cw($sformatf("reset %h", INSTR), '0);
      check_addr($sformatf("reset %h", INSTR), INSTR);
    end
    RST = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT in FETCH; abort_after > 0 asserts RST after that step.
  task automatic run_instr(input logic [15:0] instr, input int abort_after, input int zero_mode);
    string tag;
    build(instr);
    INSTR = instr;
    for (int i = 0; i < exp_q.size(); i++) begin
      ZERO = (zero_mode < 0) ? 1'($urandom) : 1'(zero_mode);
      #1;
      tag = $sformatf("instr %h step %0d", instr, i);
      check_cw(tag, exp_q[i]);
      check_addr(tag, instr);
      check_inv(tag);
      if (abort_after == i + 1) begin
        RST = 1'b1;
        @(negedge clk);
        #1;
        check_cw($sformatf("abort %h", instr), '0);
        check_inv($sformatf("abort %h", instr));
        RST = 1'b0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] op;
    RST   = 1'b1;
    INSTR = 16'h0000;
    ZERO  = 1'b0;

    do_reset(2);
    run_instr(16'h0000, 0, -1);
    run_instr(16'h1298, 0, -1);
    run_instr(16'h5A85, 0, -1);
    run_instr(16'h6A85, 0, -1);
    run_instr(16'h7283, 0, 1);
    run_instr(16'h7283, 0, 0);
    run_instr(16'h8123, 0, -1);
    run_instr(16'h9ABC, 0, -1);
    run_instr(16'h2B5D, 0, -1);
    run_instr(16'h3C6E, 0, -1);
    run_instr(16'h4FC1, 0, -1);
    run_instr(16'h5A85, 4, -1);
    run_instr(16'h1298, 0, -1);

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 14));
      run_instr({op, 12'($urandom)}, 0, -1);
    end

    run_instr(16'hF000, 0, -1);
    do_reset(1);
    run_instr(16'h6A85, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
